// File: rtl/switches_mgmt.sv
// Purpose: bus-mapped input block that synchronises and debounces 10 slide switches and 4 active-low keys.
// Latency: reads return 1 cycle after rd_en&select; writes act on the sampling edge; inputs settle in 2+DEBOUNCE_CYCLES cycles.
// Backpressure: none, the bus is always accepted; data_out holds its value between reads.
//
// Ports: clk/rst_n (async active-low); addr[4:2] selects SW/KEY/EDGE/MASK; wr_en, rd_en and select form the
// bus strobes; data_in/data_out carry bus data; sw_in/key_n_in are the raw pins; irq is a level interrupt.
// Optional feature macro: SWITCHES_IRQ_EN implements the MASK register and drives irq from masked key edges.
module switches_mgmt #(
    parameter int DEBOUNCE_CYCLES = 50000,
    parameter int CNT_W           = $clog2(DEBOUNCE_CYCLES)
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [31:0] addr,
    input  logic        wr_en,
    input  logic        rd_en,
    input  logic        select,
    input  logic [31:0] data_in,
    output logic [31:0] data_out,
    input  logic [9:0]  sw_in,
    input  logic [3:0]  key_n_in,
    output logic        irq
);

    localparam int N_IN = 14;
    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(DEBOUNCE_CYCLES - 1);
    // Sync flops hold raw pin polarity, so released keys reset to 1.
    localparam logic [N_IN-1:0] SYNC_RST = {4'hF, 10'h000};

    localparam logic [2:0] OFF_SW   = 3'b000;
    localparam logic [2:0] OFF_KEY  = 3'b001;
    localparam logic [2:0] OFF_EDGE = 3'b010;
    localparam logic [2:0] OFF_MASK = 3'b011;

    logic [N_IN-1:0]  sync1;
    logic [N_IN-1:0]  sync2;
    logic [N_IN-1:0]  sync_bit;
    logic [N_IN-1:0]  db;
    logic [N_IN-1:0]  db_next;
    logic [CNT_W-1:0] cnt      [N_IN];
    logic [CNT_W-1:0] cnt_next [N_IN];

    logic [9:0]  sw_db;
    logic [3:0]  key_db;
    logic [3:0]  key_rise;
    logic [3:0]  edge_cap;
    logic [3:0]  edge_clr;
    logic [3:0]  irq_mask;
    logic        bus_wr;
    logic        bus_rd;
    logic [2:0]  offset;
    logic [31:0] rd_dat;

    // Bus bits that no register decodes.
    logic unused_bits;
    assign unused_bits = ^{addr[31:5], addr[1:0], data_in[31:4]};

    assign offset = addr[4:2];
    assign bus_wr = wr_en & select;
    assign bus_rd = rd_en & select;

    // Two-flop synchroniser on the raw pins.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync1 <= SYNC_RST;
            sync2 <= SYNC_RST;
        end else begin
            sync1 <= {key_n_in, sw_in};
            sync2 <= sync1;
        end
    end

    // Keys flip to 1 = pressed only after synchronisation.
    assign sync_bit = {~sync2[13:10], sync2[9:0]};

    // Per-input debounce: the counter tracks how long the synchronised bit has disagreed
    // with the debounced bit; the bit flips on the DEBOUNCE_CYCLES-th disagreeing cycle.
    always_comb begin
        db_next = db;
        for (int i = 0; i < N_IN; i++) begin
            cnt_next[i] = cnt[i];
            if (sync_bit[i] == db[i]) begin
                cnt_next[i] = '0;
            end else if (cnt[i] == CNT_MAX) begin
                db_next[i]  = sync_bit[i];
                cnt_next[i] = '0;
            end else begin
                cnt_next[i] = cnt[i] + 1'b1;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            db <= '0;
            for (int i = 0; i < N_IN; i++) begin
                cnt[i] <= '0;
            end
        end else begin
            db <= db_next;
            for (int i = 0; i < N_IN; i++) begin
                cnt[i] <= cnt_next[i];
            end
        end
    end

    assign sw_db  = db[9:0];
    assign key_db = db[13:10];

    // Rising edge taken from the next-state so capture lands on the same edge key_db rises.
    assign key_rise = db_next[13:10] & ~key_db;
    assign edge_clr = (bus_wr && offset == OFF_EDGE) ? data_in[3:0] : 4'b0000;

    // Set is OR-ed after the clear so a press in the clearing cycle survives.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            edge_cap <= 4'b0000;
        end else begin
            edge_cap <= (edge_cap & ~edge_clr) | key_rise;
        end
    end

`ifdef SWITCHES_IRQ_EN
    logic irq_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            irq_mask <= 4'b0000;
            irq_q    <= 1'b0;
        end else begin
            if (bus_wr && offset == OFF_MASK) begin
                irq_mask <= data_in[3:0];
            end
            irq_q <= |(edge_cap & irq_mask);
        end
    end

    assign irq = irq_q;
`else
    assign irq_mask = 4'b0000;
    assign irq      = 1'b0;
`endif

    // Read mux uses current register values, so a read racing a write-clear sees the pre-clear state.
    always_comb begin
        rd_dat = 32'h0;
        case (offset)
            OFF_SW:   rd_dat = {22'b0, sw_db};
            OFF_KEY:  rd_dat = {28'b0, key_db};
            OFF_EDGE: rd_dat = {28'b0, edge_cap};
            OFF_MASK: rd_dat = {28'b0, irq_mask};
            default:  rd_dat = 32'h0;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            data_out <= 32'h0;
        end else if (bus_rd) begin
            data_out <= rd_dat;
        end
    end

endmodule
